// File: rtl/recv_serial_pkg.sv
// rtl/recv_serial_pkg.sv - shared definitions for the serial receiver: FSM encodings, data width, FIFO depth, flag bits
package recv_serial_pkg;

    localparam int DATA_W       = 8;
    localparam int FIFO_DEPTH   = 4;
    localparam int FLAG_FRM_BIT = 0;
    localparam int FLAG_OVR_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/recv_serial_fifo.sv
// rtl/recv_serial_fifo.sv - 4-entry receive FIFO, built only when RECV_SERIAL_FIFO_EN is defined
`ifdef RECV_SERIAL_FIFO_EN
module recv_serial_fifo
    import recv_serial_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [1:0]        wr_ptr_q;
    logic [1:0]        rd_ptr_q;
    logic [2:0]        count_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == 3'd0);
    assign full    = (count_q == 3'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + 3'(do_push) - 3'(do_pop);
        end
    end

    // Entry storage; contents need no reset since occupancy guards reads
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule
`endif

// File: rtl/recv_serial.sv
// rtl/recv_serial.sv - 8N1 serial receiver with Wishbone read port; RECV_SERIAL_FIFO_EN selects 4-entry FIFO storage
module recv_serial
    import recv_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rrx_,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    output logic              rx_valid_o,
    output logic              frame_err_o,
    output logic              overrun_o
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT - 1);

    logic              sync1_q;
    logic              sync2_q;
    rx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              push;
    logic              frm_set;

    logic              wb_req;
    logic              rd_req;
    logic              wr_req;
    logic              pop;
    logic              ovr_set;
    logic              st_full;
    logic              st_empty;
    logic [DATA_W-1:0] st_dout;
    logic [DATA_W-3:0] unused_dat;

    assign unused_dat = wb_dat_i[DATA_W-1:2];

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rrx_;
            sync2_q <= sync1_q;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state: start bit checked at its midpoint, later bits sampled one bit period apart
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        frm_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
                if (!sync2_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shreg_d = {sync2_q, shreg_q[DATA_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    push    = sync2_q;
                    frm_set = ~sync2_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ack is only granted from an idle ack, which forces a gap between acks
    assign wb_req  = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign rd_req  = wb_req & ~wb_we_i;
    assign wr_req  = wb_req & wb_we_i;
    assign pop     = rd_req & ~st_empty;
    assign ovr_set = push & st_full & ~pop;

`ifdef RECV_SERIAL_FIFO_EN
    recv_serial_fifo u_fifo (
        .clk    (wb_clk_i),
        .resetn (wb_rst_i),
        .push   (push),
        .pop    (pop),
        .din    (shreg_q),
        .dout   (st_dout),
        .full   (st_full),
        .empty  (st_empty)
    );
`else
    logic [DATA_W-1:0] hold_q;
    logic              hold_vld_q;

    assign st_dout  = hold_q;
    assign st_full  = hold_vld_q;
    assign st_empty = ~hold_vld_q;

    // Single holding register; a simultaneous pop makes room for the incoming byte
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            if (push && (!hold_vld_q || pop)) begin
                hold_q     <= shreg_q;
                hold_vld_q <= 1'b1;
            end else if (pop) begin
                hold_vld_q <= 1'b0;
            end
        end
    end
`endif

    assign rx_valid_o = ~st_empty;

    // Bus response: one-cycle ack, read data held until the next read
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= wb_req;
            if (rd_req) wb_dat_o <= st_empty ? '0 : st_dout;
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frm_set | (frame_err_o & ~(wr_req & wb_dat_i[FLAG_FRM_BIT]));
            overrun_o   <= ovr_set | (overrun_o & ~(wr_req & wb_dat_i[FLAG_OVR_BIT]));
        end
    end

endmodule
